// File: rtl/crc_generator_if.sv
// Handshake and data bundle between the CRC-8 generator and its producer/consumer.
// The slave modport is the generator's view; master is the driving side.
interface crc_generator_if;
  logic        set;
  logic [0:63] data_in;
  logic        busy;
  logic [0:7]  crc;
  logic [0:71] frame_out;
  logic        frame_valid;
  logic        frame_ready;

  modport master (
    output set, data_in, frame_ready,
    input  busy, crc, frame_out, frame_valid
  );

  modport slave (
    input  set, data_in, frame_ready,
    output busy, crc, frame_out, frame_valid
  );
endinterface

// File: rtl/crc_generator.sv
// Bit-serial CRC-8 generator: shifts a 64-bit word MSB-first through an LFSR,
// then holds {payload, crc} under a valid/ready handshake.
module crc_generator #(
  parameter logic [7:0] POLY = 8'h07,
  parameter logic [7:0] INIT = 8'h00
) (
  input logic           clk,
  input logic           rst,
  crc_generator_if.slave bus
);

  // state | meaning
  // IDLE  | waiting for set
  // SHIFT | one payload bit per cycle into the LFSR
  // DONE  | frame presented, waiting for frame_ready
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [0:63] payload_q, payload_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [0:71] frame_q, frame_d;
  logic        fb;
  logic [7:0]  lfsr_step;

  always_comb begin
    fb        = payload_q[cnt_q] ^ lfsr_q[7];
    lfsr_step = {lfsr_q[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    payload_d = payload_q;
    lfsr_d    = lfsr_q;
    frame_d   = frame_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.set) begin
          payload_d = bus.data_in;
          lfsr_d    = INIT;
          cnt_d     = 6'd0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        lfsr_d = lfsr_step;
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'd63) begin
          // Published frame lives in its own register so it survives the next word.
          frame_d = {payload_q, lfsr_step};
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.frame_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 6'd0;
      payload_q <= '0;
      lfsr_q    <= 8'h00;
      frame_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      payload_q <= payload_d;
      lfsr_q    <= lfsr_d;
      frame_q   <= frame_d;
    end
  end

  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.frame_valid = (state_q == ST_DONE);
  assign bus.frame_out   = frame_q;
  assign bus.crc         = frame_q[64:71];

endmodule
